// File: rtl/alu_rs_ooo_if.sv
// alu_rs_ooo_if: dispatch, CDB snoop, result and flush bundle for the ALU reservation station
//   master: decoder/CDB/ROB side (drives flush, disp_*, cdb_*, res_ready)
//   slave : reservation station (drives disp_ready, res_*, occupancy)
interface alu_rs_ooo_if #(
  parameter int RS_DEPTH = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W = 4,
  parameter int OP_W = 4,
  parameter int NUM_CDB = 2,
  parameter int IDX_W = $clog2(RS_DEPTH)
);
  logic flush;
  logic disp_valid;
  logic disp_ready;
  logic [OP_W-1:0] disp_op;
  logic [TAG_W-1:0] disp_dest;
  logic [TAG_W-1:0] disp_tag1;
  logic [TAG_W-1:0] disp_tag2;
  logic [DATA_W-1:0] disp_data1;
  logic [DATA_W-1:0] disp_data2;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic res_valid;
  logic res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0] res_idx;
  logic [IDX_W:0] occupancy;
  modport master (
    output flush, disp_valid, disp_op, disp_dest, disp_tag1, disp_tag2, disp_data1, disp_data2,
    output cdb_valid, cdb_tag, cdb_data, res_ready,
    input disp_ready, res_valid, res_tag, res_data, res_idx, occupancy
  );
  modport slave (
    input flush, disp_valid, disp_op, disp_dest, disp_tag1, disp_tag2, disp_data1, disp_data2,
    input cdb_valid, cdb_tag, cdb_data, res_ready,
    output disp_ready, res_valid, res_tag, res_data, res_idx, occupancy
  );
endinterface

// File: rtl/alu_rs_ooo.sv
// alu_rs_ooo: age-ordered ALU reservation station with CDB wakeup and a backpressured result register
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_rs_ooo_if.slave (flush, dispatch handshake, CDB snoop ports, result port, occupancy)
module alu_rs_ooo #(
  parameter int RS_DEPTH = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = '0,
  parameter int OP_W = 4,
  parameter int NUM_CDB = 2,
  parameter int IDX_W = $clog2(RS_DEPTH)
) (
  input logic clk,
  input logic rst,
  alu_rs_ooo_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(8);
  localparam logic [OP_W-1:0] OP_OR = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(10);
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [RS_DEPTH-1:0] valid_q;
  logic [OP_W-1:0] op_q [RS_DEPTH];
  logic [TAG_W-1:0] dest_q [RS_DEPTH];
  logic [TAG_W-1:0] tag1_q [RS_DEPTH];
  logic [TAG_W-1:0] tag2_q [RS_DEPTH];
  logic [DATA_W-1:0] data1_q [RS_DEPTH];
  logic [DATA_W-1:0] data2_q [RS_DEPTH];
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [IDX_W:0] occ_q;
  logic res_valid_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [DATA_W-1:0] res_data_q;
  logic [DATA_W-1:0] res_data_d;
  logic [IDX_W-1:0] res_idx_q;
  logic [RS_DEPTH-1:0] rdy;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] alloc;
  logic has_rdy;
  logic issue;
  logic store;
  logic [DATA_W:0] byp1;
  logic [DATA_W:0] byp2;
  logic [DATA_W:0] wk1 [RS_DEPTH];
  logic [DATA_W:0] wk2 [RS_DEPTH];
  assign cdb_valid = bus.cdb_valid;
  assign cdb_tag = bus.cdb_tag;
  assign cdb_data = bus.cdb_data;
  // {hit, data} for a pending tag; the lowest matching port wins
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] t);
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--)
      if (t != TAG_FREE && cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) r = {1'b1, cdb_data[p*DATA_W +: DATA_W]};
    return r;
  endfunction
  function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [SH_W-1:0] sh;
    logic [DATA_W-1:0] sra;
    logic lt_s;
    sh = b[SH_W-1:0];
    // kept out of the ternary chain so the shift and compare stay signed
    sra = $unsigned($signed(a) >>> sh);
    lt_s = $signed(a) < $signed(b);
    return op == OP_ADD ? a + b :
      op == OP_SUB ? a - b :
      op == OP_SLL ? a << sh :
      op == OP_SLT ? DATA_W'(lt_s) :
      op == OP_SLTU ? DATA_W'(a < b) :
      op == OP_XOR ? a ^ b :
      op == OP_SRL ? a >> sh :
      op == OP_SRA ? sra :
      op == OP_OR ? a | b :
      op == OP_AND ? a & b : '0;
  endfunction
  always_comb begin
    rdy = '0;
    sel = '0;
    alloc = '0;
    has_rdy = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) rdy[i] = valid_q[i] && tag1_q[i] == TAG_FREE && tag2_q[i] == TAG_FREE;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (rdy[i] && !(|(rdy & older_q[i]))) begin
        sel = IDX_W'(i);
        has_rdy = 1'b1;
      end
      if (!valid_q[i]) alloc = IDX_W'(i);
    end
  end
  always_comb begin
    wk1 = '{default: '0};
    wk2 = '{default: '0};
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk1[i] = snoop(tag1_q[i]);
      wk2[i] = snoop(tag2_q[i]);
    end
    byp1 = snoop(bus.disp_tag1);
    byp2 = snoop(bus.disp_tag2);
  end
  assign bus.disp_ready = occ_q != (IDX_W+1)'(RS_DEPTH);
  assign issue = has_rdy && (!res_valid_q || bus.res_ready) && !bus.flush;
  assign store = bus.disp_valid && bus.disp_ready && !bus.flush && bus.disp_op != OP_NOP;
  assign res_data_d = alu(op_q[sel], data1_q[sel], data2_q[sel]);
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
      occ_q <= '0;
      res_valid_q <= 1'b0;
      res_tag_q <= TAG_FREE;
      res_data_q <= '0;
      res_idx_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && wk1[i][DATA_W]) begin
          tag1_q[i] <= TAG_FREE;
          data1_q[i] <= wk1[i][DATA_W-1:0];
        end
        if (valid_q[i] && wk2[i][DATA_W]) begin
          tag2_q[i] <= TAG_FREE;
          data2_q[i] <= wk2[i][DATA_W-1:0];
        end
      end
      if (issue) begin
        valid_q[sel] <= 1'b0;
        res_valid_q <= 1'b1;
        res_tag_q <= dest_q[sel];
        res_data_q <= res_data_d;
        res_idx_q <= sel;
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (store) begin
        valid_q[alloc] <= 1'b1;
        op_q[alloc] <= bus.disp_op;
        dest_q[alloc] <= bus.disp_dest;
        tag1_q[alloc] <= byp1[DATA_W] ? TAG_FREE : bus.disp_tag1;
        data1_q[alloc] <= byp1[DATA_W] ? byp1[DATA_W-1:0] : bus.disp_data1;
        tag2_q[alloc] <= byp2[DATA_W] ? TAG_FREE : bus.disp_tag2;
        data2_q[alloc] <= byp2[DATA_W] ? byp2[DATA_W-1:0] : bus.disp_data2;
        // new entry is younger than everyone; stale bits of free slots are masked by rdy
        for (int j = 0; j < RS_DEPTH; j++) older_q[j][alloc] <= 1'b0;
        older_q[alloc] <= ~(RS_DEPTH'(1) << alloc);
      end
      occ_q <= occ_q + (IDX_W+1)'(store) - (IDX_W+1)'(issue);
    end
  end
  assign bus.res_valid = res_valid_q;
  assign bus.res_tag = res_tag_q;
  assign bus.res_data = res_data_q;
  assign bus.res_idx = res_idx_q;
  assign bus.occupancy = occ_q;
endmodule
